// File: rtl/wb_demux_pkg.sv
// Shared definitions for the write-back demultiplexer: default geometry
// and the holding-buffer state encoding.
package wb_demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NDEST_DEF = 4;
  localparam int SELW_DEF  = 2;

  // EMPTY: nothing buffered. FULL: one item held in data_q/sel_q.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/wb_demux_if.sv
// Result-bus bundle between the ALU side (producer) and the destination
// registers (consumers).
//
// Handshake rules, both sides: a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on the other
// side, valid never depends on ready. On the output side the valid is one-hot
// and bit i pairs with out_ready[i]; out_data is shared by all destinations.
interface wb_demux_if
  import wb_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NDEST = NDEST_DEF,
  parameter int SELW  = SELW_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SELW-1:0]  in_sel;
  logic [NDEST-1:0] out_valid;
  logic [NDEST-1:0] out_ready;
  logic [WIDTH-1:0] out_data;

  // Demux side: accepts results, offers them to one destination.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: drives results and destination readies.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/wb_demux_sat_counter8.sv
// 8-bit event counter; sat=1 sticks at 255, sat=0 wraps 255->0.
module sat_counter8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sat,
  output logic [7:0] count
);

  // Count enabled events, holding at the top value only in saturate mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (en && !(sat && (count == 8'hFF))) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/wb_demux.sv
// 1-to-NDEST write-back demultiplexer with a single-entry holding buffer.
// Input is registered before being offered, so there is no combinational
// in->out path; in_ready passes through when the held item leaves this cycle.
module wb_demux
  import wb_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NDEST = NDEST_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  wb_demux_if.slave   bus,
  output logic [7:0]  xfer_count,
  output logic [7:0]  err_count,
  output state_t      state
);

  localparam logic [SELW:0] NDEST_L = (SELW+1)'(NDEST);

  state_t           state_q;
  state_t           state_n;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             sel_ok;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             load;
  logic             err_inc;

  assign sel_ok   = ({1'b0, bus.in_sel} < NDEST_L);
  assign out_fire = (state_q == ST_FULL) && bus.out_ready[sel_q];
  assign in_ready = (state_q == ST_EMPTY) || out_fire;
  assign in_fire  = bus.in_valid && in_ready;
  assign err_inc  = in_fire && !sel_ok;

  assign bus.in_ready = in_ready;
  assign bus.out_data = data_q;
  assign state        = state_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and buffer load; invalid selects are dropped, never buffered.
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire && sel_ok) begin
          state_n = ST_FULL;
          load    = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          if (in_fire && sel_ok) begin
            state_n = ST_FULL;
            load    = 1'b1;
          end else begin
            state_n = ST_EMPTY;
          end
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Holding buffer; keeps its contents while EMPTY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (load) begin
      data_q <= bus.in_data;
      sel_q  <= bus.in_sel;
    end
  end

  // One-hot decode of the held destination, all zero while EMPTY.
  always_comb begin
    bus.out_valid = '0;
    for (int i = 0; i < NDEST; i++) begin
      bus.out_valid[i] = (state_q == ST_FULL) && (sel_q == SELW'(i));
    end
  end

  sat_counter8 u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_fire),
    .sat   (1'b0),
    .count (xfer_count)
  );

  sat_counter8 u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (err_inc),
    .sat   (1'b1),
    .count (err_count)
  );

endmodule

// File: tb/tb_wb_demux.sv
// Bench for wb_demux: instance a (4 destinations) carries the data-path
// scenarios, instance b (3 destinations) covers invalid selects.
module tb_wb_demux;
  import wb_demux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_demux_if #(.WIDTH(8), .NDEST(4), .SELW(2)) a ();
  wb_demux_if #(.WIDTH(8), .NDEST(3), .SELW(2)) b ();

  logic [7:0] a_xfer, a_err, b_xfer, b_err;
  state_t     a_state, b_state;

  wb_demux #(.WIDTH(8), .NDEST(4), .SELW(2)) dut_a (
    .clk(clk), .reset(reset), .bus(a),
    .xfer_count(a_xfer), .err_count(a_err), .state(a_state)
  );

  wb_demux #(.WIDTH(8), .NDEST(3), .SELW(2)) dut_b (
    .clk(clk), .reset(reset), .bus(b),
    .xfer_count(b_xfer), .err_count(b_err), .state(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected output transfers of instance a: {one-hot valid, data}.
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver ----------------
  // Call at posedge+1. Offers one item to instance a, holds it until taken,
  // and returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input bit exp_out,
                      output int waits);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    waits = 0;
    a.in_valid = 1'b1;
    a.in_data  = d;
    a.in_sel   = s;
    @(negedge clk);
    while (!a.in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!a.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: data 0x%0h not taken in 20 cycles, required acceptance", d);
    end else if (exp_out) begin
      exp_q.push_back({oh, d});
    end
    @(posedge clk);
    #1;
    a.in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every output transfer of instance a must match the next expected item.
  always @(negedge clk) begin
    if (!reset && ((a.out_valid & a.out_ready) != 4'b0000)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got valid=%b data=0x%0h, required no transfer",
                 a.out_valid, a.out_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({a.out_valid, a.out_data} !== e) begin
          n_bad++;
          $display("FAIL out_item: got valid=%b data=0x%0h, required valid=%b data=0x%0h",
                   a.out_valid, a.out_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    a.in_valid = 1'b0; a.in_data = 8'h00; a.in_sel = 2'd0; a.out_ready = 4'b0000;
    b.in_valid = 1'b0; b.in_data = 8'h00; b.in_sel = 2'd0; b.out_ready = 3'b000;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", a.out_valid, 4'b0000);
    check("rst_out_data",  a.out_data, 8'h00);
    check("rst_xfer",      a_xfer, 8'd0);
    check("rst_err",       a_err, 8'd0);
    check("rst_state",     a_state, ST_EMPTY);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", a.in_ready, 1'b1);
    cyc(1);

    // Single item to destination 0
    a.out_ready = 4'b0001;
    send(8'h01, 2'd0, 1'b1, w);
    @(negedge clk);
    check("t1_in_ready_full", a.in_ready, 1'b1);
    cyc(1);
    check("t1_xfer", a_xfer, 8'd1);

    // Stall on destination 1, a second item must wait
    a.out_ready = 4'b0000;
    send(8'h02, 2'd1, 1'b1, w);
    a.in_valid = 1'b1; a.in_data = 8'hFF; a.in_sel = 2'd2;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", a.out_valid, 4'b0010);
      check("stall_data",  a.out_data, 8'h02);
      check("stall_ready", a.in_ready, 1'b0);
      cyc(1);
    end
    a.out_ready = 4'b0010;
    send(8'hFF, 2'd2, 1'b1, w);
    check("stall_passthru_wait", w, 0);
    a.out_ready = 4'b0100;
    cyc(2);
    check("stall_xfer", a_xfer, 8'd3);

    // Back-to-back stream, one item per cycle
    a.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      send(d, 2'(i), 1'b1, w);
      check("b2b_wait", w, 0);
    end
    cyc(1);
    check("b2b_xfer", a_xfer, 8'd7);

    // Ready on the wrong destinations is ignored
    a.out_ready = 4'b1011;
    send(8'h20, 2'd2, 1'b1, w);
    repeat (3) begin
      @(negedge clk);
      check("wrong_rdy_valid", a.out_valid, 4'b0100);
      check("wrong_rdy_in_ready", a.in_ready, 1'b0);
      cyc(1);
    end
    check("wrong_rdy_xfer_hold", a_xfer, 8'd7);
    a.out_ready = 4'b1111;
    cyc(1);
    check("wrong_rdy_xfer", a_xfer, 8'd8);

    // Invalid select on a 3-destination instance
    b.out_ready = 3'b111;
    b.in_valid = 1'b1; b.in_sel = 2'd3; b.in_data = 8'hAA;
    @(negedge clk);
    check("inv_in_ready", b.in_ready, 1'b1);
    cyc(1);
    b.in_valid = 1'b0;
    check("inv_err1", b_err, 8'd1);
    check("inv_out_valid", b.out_valid, 3'b000);
    check("inv_state", b_state, ST_EMPTY);

    // FULL, output fires while an invalid item arrives -> EMPTY
    b.out_ready = 3'b000;
    b.in_valid = 1'b1; b.in_sel = 2'd2; b.in_data = 8'h77;
    cyc(1);
    b.in_sel = 2'd3; b.in_data = 8'hBB;
    @(negedge clk);
    check("inv_full_in_ready", b.in_ready, 1'b0);
    check("inv_full_valid", b.out_valid, 3'b100);
    check("inv_full_data", b.out_data, 8'h77);
    cyc(1);
    b.out_ready = 3'b100;
    @(negedge clk);
    check("inv_pass_in_ready", b.in_ready, 1'b1);
    cyc(1);
    b.in_valid = 1'b0;
    check("inv_pass_valid", b.out_valid, 3'b000);
    check("inv_pass_state", b_state, ST_EMPTY);
    check("inv_pass_xfer", b_xfer, 8'd1);
    check("inv_pass_err", b_err, 8'd2);
    check("inv_hold_data", b.out_data, 8'h77);

    // Error counter saturation
    b.in_valid = 1'b1; b.in_sel = 2'd3;
    cyc(300);
    b.in_valid = 1'b0;
    check("err_sat", b_err, 8'd255);
    check("err_sat_valid", b.out_valid, 3'b000);

    // Reset in the middle of a stalled item
    a.out_ready = 4'b0000;
    send(8'h33, 2'd1, 1'b0, w);
    @(negedge clk);
    check("midrst_before", a.out_valid, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", a.out_valid, 4'b0000);
    check("midrst_xfer",  a_xfer, 8'd0);
    check("midrst_err_b", b_err, 8'd0);
    check("midrst_state", a_state, ST_EMPTY);
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", a.in_ready, 1'b1);
    a.out_ready = 4'b0001;
    send(8'h5A, 2'd0, 1'b1, w);
    cyc(1);
    check("midrst_xfer_after", a_xfer, 8'd1);
    check("midrst_data_after", a.out_data, 8'h5A);

    cyc(2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
